// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store front end between the pipeline and a split
// address/data handshake bus. It checks alignment, drives byte lanes,
// extracts and extends load data, and handles flush and timeout cases.
module mem_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              excp_in_i,
    input  logic              flush_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_addr_ok_i,
    input  logic              bus_data_ok_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       rdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] bad_addr_o,
    output logic              err_o,
    output logic              stall_o
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;

    // Last counter value still allowed in a wait state.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Access size: 0 = byte, 1 = half, 2 = word.
    function automatic logic [1:0] op_size(input logic [2:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = 2'd0;
            OP_LH, OP_LHU, OP_SH: op_size = 2'd1;
            default:              op_size = 2'd2;
        endcase
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        is_store = (op >= OP_SB);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op_size(op))
            2'd1:    misaligned = lo[0];
            2'd2:    misaligned = (lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_sel(input logic [2:0] op, input logic [1:0] lo);
        case (op_size(op))
            2'd0:    lane_sel = 4'b0001 << lo;
            2'd1:    lane_sel = 4'b0011 << lo;
            default: lane_sel = 4'b1111;
        endcase
    endfunction

    // Store data is replicated so every enabled lane carries the operand.
    function automatic logic [31:0] store_data(input logic [2:0] op, input logic [31:0] wd);
        case (op_size(op))
            2'd0:    store_data = {4{wd[7:0]}};
            2'd1:    store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // Pick the addressed lane and extend it; stores yield zero.
    function automatic logic [31:0] load_data(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> {lo, 3'b000});
        h = lo[1] ? rd[31:16] : rd[15:0];
        case (op)
            OP_LB:   load_data = {{24{b[7]}}, b};
            OP_LBU:  load_data = {24'd0, b};
            OP_LH:   load_data = {{16{h[15]}}, h};
            OP_LHU:  load_data = {16'd0, h};
            OP_LW:   load_data = rd;
            default: load_data = 32'd0;
        endcase
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [2:0]          op_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [15:0]         cnt_r;
    logic                drain_pend_r;
    logic [31:0]         rdata_r;
    logic [ADDR_W-1:0]   bad_addr_r;
    logic                adel_r;
    logic                ades_r;
    logic                err_r;

    logic ready_s;
    logic accept_s;
    logic mis_s;
    logic fault_s;
    logic tmo_s;
    logic resp_fault_s;
    logic resp_data_s;
    logic resp_tmo_s;
    logic in_addr_s;

    assign ready_s      = (state_r == S_IDLE) & ~flush_i;
    assign accept_s     = req_valid_i & ready_s;
    assign mis_s        = misaligned(op_i, addr_i[1:0]);
    assign fault_s      = excp_in_i | mis_s;
    assign tmo_s        = (cnt_r == TMO_LAST);
    assign in_addr_s    = (state_r == S_ADDR);
    assign resp_fault_s = accept_s & fault_s;
    assign resp_data_s  = ~flush_i & bus_data_ok_i &
                          ((in_addr_s & bus_addr_ok_i) | (state_r == S_DATA));
    assign resp_tmo_s   = ~flush_i & tmo_s &
                          ((in_addr_s & ~bus_addr_ok_i) | ((state_r == S_DATA) & ~bus_data_ok_i));

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; flush always wins over timeout.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nx_s = fault_s ? S_RESP : S_ADDR;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (flush_i) begin
                    // An accepted address still owes a data beat unless it arrived now.
                    state_nx_s = (bus_addr_ok_i & ~bus_data_ok_i) ? S_DRAIN : S_IDLE;
                end else if (bus_addr_ok_i) begin
                    state_nx_s = bus_data_ok_i ? S_RESP : S_DATA;
                end else if (tmo_s) begin
                    state_nx_s = S_RESP;
                end else begin
                    state_nx_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (bus_data_ok_i) begin
                    state_nx_s = flush_i ? S_IDLE : S_RESP;
                end else if (flush_i) begin
                    state_nx_s = S_DRAIN;
                end else if (tmo_s) begin
                    state_nx_s = S_RESP;
                end else begin
                    state_nx_s = S_DATA;
                end
            end
            S_DRAIN: begin
                state_nx_s = bus_data_ok_i ? S_IDLE : S_DRAIN;
            end
            S_RESP: begin
                // A timed-out data phase must still swallow its late data beat.
                state_nx_s = (drain_pend_r & ~bus_data_ok_i) ? S_DRAIN : S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Request capture at accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_r    <= 3'd0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            op_r    <= op_i;
            addr_r  <= addr_i;
            wdata_r <= wdata_i;
        end
    end

    // Wait counter: restarts on entry to each wait state, idles at zero elsewhere.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= 16'd0;
        end else if ((state_nx_s != state_r) &&
                     ((state_nx_s == S_ADDR) || (state_nx_s == S_DATA))) begin
            cnt_r <= 16'd0;
        end else if (in_addr_s || (state_r == S_DATA)) begin
            cnt_r <= cnt_r + 16'd1;
        end else begin
            cnt_r <= 16'd0;
        end
    end

    // Response payload, loaded on every transition into S_RESP and held afterwards.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_r      <= 32'd0;
            bad_addr_r   <= '0;
            adel_r       <= 1'b0;
            ades_r       <= 1'b0;
            err_r        <= 1'b0;
            drain_pend_r <= 1'b0;
        end else if (resp_fault_s) begin
            rdata_r      <= 32'd0;
            bad_addr_r   <= addr_i;
            adel_r       <= ~excp_in_i & mis_s & ~is_store(op_i);
            ades_r       <= ~excp_in_i & mis_s & is_store(op_i);
            err_r        <= 1'b0;
            drain_pend_r <= 1'b0;
        end else if (resp_data_s) begin
            rdata_r      <= load_data(op_r, addr_r[1:0], bus_rdata_i);
            bad_addr_r   <= addr_r;
            adel_r       <= 1'b0;
            ades_r       <= 1'b0;
            err_r        <= 1'b0;
            drain_pend_r <= 1'b0;
        end else if (resp_tmo_s) begin
            rdata_r      <= 32'd0;
            bad_addr_r   <= addr_r;
            adel_r       <= 1'b0;
            ades_r       <= 1'b0;
            err_r        <= 1'b1;
            drain_pend_r <= (state_r == S_DATA);
        end
    end

    // Output decode from state and held registers.
    always_comb begin
        req_ready_o  = ready_s;
        stall_o      = (state_r != S_IDLE) | accept_s;
        bus_req_o    = in_addr_s;
        if (in_addr_s) begin
            bus_we_o    = is_store(op_r);
            bus_addr_o  = {addr_r[ADDR_W-1:2], 2'b00};
            bus_sel_o   = lane_sel(op_r, addr_r[1:0]);
            bus_wdata_o = store_data(op_r, wdata_r);
        end else begin
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_sel_o   = 4'd0;
            bus_wdata_o = 32'd0;
        end
        resp_valid_o = (state_r == S_RESP);
        adel_o       = resp_valid_o & adel_r;
        ades_o       = resp_valid_o & ades_r;
        err_o        = resp_valid_o & err_r;
        rdata_o      = rdata_r;
        bad_addr_o   = bad_addr_r;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the bus address width; the low 2 bits select the byte lane.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, meaning the maximum wait cycles in S_ADDR or S_DATA; legal range 1..65535.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid_i / req_ready_o, input / output, 1 bit each: the pipeline access handshake.
REQ-006 SHALL have port op_i, input, 3 bits: 0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW, 5=SB, 6=SH, 7=SW.
REQ-007 SHALL have ports addr_i (input, ADDR_W bits) and wdata_i (input, 32 bits): the access address and the store data.
REQ-008 SHALL have port excp_in_i, input, 1 bit: an older exception is pending; suppress the bus access.
REQ-009 SHALL have port flush_i, input, 1 bit: the pipeline flush; cancel the current access.
REQ-010 SHALL have bus ports bus_req_o, bus_we_o (output, 1 bit each), bus_addr_o (output, ADDR_W bits), bus_sel_o (output, 4 bits) and bus_wdata_o (output, 32 bits).
REQ-011 SHALL have bus ports bus_addr_ok_i, bus_data_ok_i (input, 1 bit each) and bus_rdata_i (input, 32 bits).
REQ-012 SHALL have outputs resp_valid_o (1), rdata_o (32), adel_o (1), ades_o (1), bad_addr_o (ADDR_W), err_o (1) and stall_o (1).

Function
REQ-013 SHALL implement FSM states S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_RESP; req_ready_o=1 only in S_IDLE with flush_i=0.
REQ-014 SHALL accept a request when req_valid_i & req_ready_o, latching op, addr and wdata.
REQ-015 SHALL flag misalignment at accept: LH/LHU with addr[0]!=0, or LW with addr[1:0]!=0 -> adel; SH/SW under the same rules -> ades.
REQ-016 SHALL, on a misaligned or excp_in_i accept, issue no bus request, go to S_RESP, and in that cycle assert resp_valid_o with the adel_o/ades_o flags and bad_addr_o=addr; for excp_in_i, both flags are 0.
REQ-017 SHALL otherwise go to S_ADDR, holding bus_req_o=1, bus_addr_o={addr[ADDR_W-1:2],2'b00} and bus_we_o=(op>=5) stable until bus_addr_ok_i.
REQ-018 SHALL generate little-endian bus_sel_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; bus_wdata_o: SB {4{b}}, SH {2{h}}, SW as-is.
REQ-019 SHALL move S_ADDR->S_DATA on bus_addr_ok_i; with bus_addr_ok_i & bus_data_ok_i in the same cycle, go directly to S_RESP.
REQ-020 SHALL, on bus_data_ok_i in S_DATA, capture the lane-selected bus_rdata_i, sign-extend it (LB/LH) or zero-extend it (LBU/LHU) into rdata_o, and go to S_RESP.
REQ-021 SHALL make S_RESP last exactly one cycle with resp_valid_o=1, then return to S_IDLE; stores return rdata_o=0.
REQ-022 SHALL drive stall_o = (state != S_IDLE) | (req_valid_i & req_ready_o).
REQ-023 SHALL handle flush_i in S_ADDR: without bus_addr_ok_i -> S_IDLE, bus_req_o drops next cycle; with bus_addr_ok_i in the same cycle -> S_DRAIN.
REQ-024 SHALL handle flush_i in S_DATA: -> S_DRAIN, unless bus_data_ok_i is in the same cycle -> S_IDLE; in neither case assert resp_valid_o.
REQ-025 SHALL wait in S_DRAIN for bus_data_ok_i, discard the data, return to S_IDLE with no response, and ignore flush_i there.
REQ-026 SHALL run a wait counter, cleared on entering S_ADDR or S_DATA, that increments each cycle; on reaching TIMEOUT_CYC it asserts err_o with resp_valid_o in S_RESP (rdata_o=0). S_ADDR then goes to S_IDLE; S_DATA goes to S_DRAIN, with the response issued before the drain.
REQ-027 SHALL hold resp_valid_o, err_o, adel_o and ades_o as single-cycle pulses, with rdata_o and bad_addr_o held until the next response.

Reset
REQ-028 SHALL, on rst_i=1 at any time (including mid-transaction), enter S_IDLE immediately; the counter=0 and every output is 0 except req_ready_o=1; any outstanding bus data_ok after reset is ignored.

Verification
REQ-029 LB, addr 0x1003, addr_ok and data_ok both 2 cycles later, rdata 0x80FFFFFF -> bus_sel 0001 pre-shift lane 3, rdata_o 0xFFFFFF80, single resp_valid pulse.
REQ-030 SH, addr 0x2002, wdata 0x0000ABCD -> bus_sel 4'b1100, bus_wdata 0xABCDABCD, bus_we 1, resp_valid, rdata_o 0.
REQ-031 LW, addr 0x3001 -> no bus_req, adel_o=1, bad_addr_o=0x3001 one cycle after accept.
REQ-032 LHU, addr 0x4000, flush_i in S_DATA, data_ok 3 cycles later -> no resp_valid, req_ready_o returns the cycle after data_ok.
REQ-033 TIMEOUT_CYC=4, addr_ok never asserted -> err_o with resp_valid 4 cycles after entering S_ADDR, then bus_req_o=0.
REQ-034 rst_i pulse during S_DATA -> outputs at their reset values asynchronously; a subsequent LW completes normally.
